// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection lamp controller:
// state encoding, lamp bit positions and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } state_e;

  localparam int unsigned LI_NS_G = 5;
  localparam int unsigned LI_NS_Y = 4;
  localparam int unsigned LI_NS_R = 3;
  localparam int unsigned LI_EW_G = 2;
  localparam int unsigned LI_EW_Y = 1;
  localparam int unsigned LI_EW_R = 0;

  localparam logic [5:0] LAMP_NS_GREEN  = 6'b100001;
  localparam logic [5:0] LAMP_NS_YELLOW = 6'b010001;
  localparam logic [5:0] LAMP_EW_GREEN  = 6'b001100;
  localparam logic [5:0] LAMP_EW_YELLOW = 6'b001010;
  localparam logic [5:0] LAMP_ALLRED    = 6'b001001;
  localparam logic [5:0] LAMP_FLASH_ON  = 6'b010010;
  localparam logic [5:0] LAMP_OFF       = 6'b000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a dwell.
module phase_timer #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= RST_VAL;
    else if (load)  count <= load_val;
    else if (!zero) count <= count - 1'b1;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light Moore FSM with dwell timers, all-red clearance,
// pedestrian early green end and night flashing-yellow mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC      = 8,
  parameter int YELLOW_CYC     = 3,
  parameter int ALLRED_CYC     = 2,
  parameter int MIN_GREEN_CYC  = 4,
  parameter int FLASH_HALF_CYC = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ped_req,
  input  logic       i_flash,
  output logic [5:0] o_light,
  output logic [2:0] o_phase,
  output logic       o_ped_pending
);

  localparam int MAX_CYC = max_int(max_int(max_int(GREEN_CYC, YELLOW_CYC),
                                           max_int(ALLRED_CYC, MIN_GREEN_CYC)),
                                   FLASH_HALF_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] G_M1 = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_M1 = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_M1 = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] F_M1 = TW'(FLASH_HALF_CYC - 1);
  // With MIN == GREEN only the natural timeout can end green.
  localparam bit            EARLY_EN = (GREEN_CYC > MIN_GREEN_CYC);
  localparam logic [TW-1:0] EARLY_TH = EARLY_EN ? TW'(GREEN_CYC - MIN_GREEN_CYC - 1) : '0;

  if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 || FLASH_HALF_CYC < 1 ||
      MIN_GREEN_CYC < 1 || MIN_GREEN_CYC > GREEN_CYC) begin : g_param_check
    $error("traffic_light_ctrl: illegal timing parameters");
  end

  state_e        state, state_nxt;
  logic          blink, blink_nxt;
  logic          ped_pending, ped_nxt;
  logic          tmr_load, tmr_zero, early_ok, is_green;
  logic [TW-1:0] tmr_val, timer;

  function automatic logic [TW-1:0] dwell_m1(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   return G_M1;
      NS_YELLOW, EW_YELLOW: return Y_M1;
      ALLRED_A, ALLRED_B:   return A_M1;
      default:              return F_M1;
    endcase
  endfunction

  function automatic state_e succ(input state_e s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_A;
      ALLRED_A:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED_B;
      default:   return NS_GREEN;
    endcase
  endfunction

  phase_timer #(.W(TW), .RST_VAL(G_M1)) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (timer),
    .zero     (tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= NS_GREEN;
      blink       <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      blink       <= blink_nxt;
      ped_pending <= ped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    blink_nxt = blink;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    is_green  = (state == NS_GREEN) || (state == EW_GREEN);
    early_ok  = tmr_zero || (EARLY_EN && (timer <= EARLY_TH));
    if (i_flash) begin
      if (state != FLASH) begin
        state_nxt = FLASH;
        blink_nxt = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = F_M1;
      end else if (tmr_zero) begin
        blink_nxt = ~blink;
        tmr_load  = 1'b1;
        tmr_val   = F_M1;
      end
    end else if (state == FLASH) begin
      state_nxt = ALLRED_B;
      blink_nxt = 1'b0;
      tmr_load  = 1'b1;
      tmr_val   = A_M1;
    end else if (tmr_zero || (is_green && ped_pending && early_ok)) begin
      state_nxt = succ(state);
      tmr_load  = 1'b1;
      tmr_val   = dwell_m1(state_nxt);
    end
    // A new request on the all-red entry edge survives the clear.
    ped_nxt = i_ped_req | (ped_pending &
              ~((state_nxt != state) && (state_nxt == ALLRED_A || state_nxt == ALLRED_B)));
  end

  always_comb begin
    o_light = LAMP_ALLRED;
    case (state)
      NS_GREEN:  o_light = LAMP_NS_GREEN;
      NS_YELLOW: o_light = LAMP_NS_YELLOW;
      EW_GREEN:  o_light = LAMP_EW_GREEN;
      EW_YELLOW: o_light = LAMP_EW_YELLOW;
      FLASH:     o_light = blink ? LAMP_FLASH_ON : LAMP_OFF;
      default:   o_light = LAMP_ALLRED;
    endcase
  end

  assign o_phase       = state;
  assign o_ped_pending = ped_pending;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: phase/elapsed-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized ped/flash traffic.
module tb_traffic_light_ctrl;

  localparam int G = 8, Y = 3, A = 2, MING = 4, H = 2;

  logic       i_clk = 1'b0, i_rst_n = 1'b1, i_ped_req = 1'b0, i_flash = 1'b0;
  logic [5:0] o_light;
  logic [2:0] o_phase;
  logic       o_ped_pending;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  traffic_light_ctrl #(
    .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A),
    .MIN_GREEN_CYC(MING), .FLASH_HALF_CYC(H)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ped_req(i_ped_req), .i_flash(i_flash),
    .o_light(o_light), .o_phase(o_phase), .o_ped_pending(o_ped_pending)
  );

  always #5 i_clk = ~i_clk;

  // Model: phase index in the 6-step cycle, cycles elapsed in it, flash cycle count.
  int         dwell [6] = '{G, Y, A, G, Y, A};
  logic [5:0] lamp  [6] = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
  int m_ph = 0, m_e = 0, m_f = 0;
  bit m_flash = 1'b0, m_pend = 1'b0, m_clr;

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_ph = 0; m_e = 0; m_f = 0; m_flash = 1'b0; m_pend = 1'b0;
    end else begin
      m_clr = 1'b0;
      if (i_flash) begin
        if (m_flash) m_f++;
        else begin m_flash = 1'b1; m_f = 0; end
      end else if (m_flash) begin
        m_flash = 1'b0; m_ph = 5; m_e = 0; m_clr = 1'b1;
      end else if (m_e == dwell[m_ph] - 1 ||
                   ((m_ph == 0 || m_ph == 3) && m_pend && m_e >= MING)) begin
        m_ph = (m_ph + 1) % 6; m_e = 0; m_clr = (m_ph == 2 || m_ph == 5);
      end else begin
        m_e++;
      end
      m_pend = i_ped_req | (m_pend & !m_clr);
    end
  end

  function automatic logic [5:0] exp_light();
    if (m_flash) return (((m_f / H) % 2) == 0) ? 6'b010010 : 6'b000000;
    return lamp[m_ph];
  endfunction

  function automatic logic [2:0] exp_phase();
    return m_flash ? 3'd6 : 3'(m_ph);
  endfunction

  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      n_tests++;
      if (o_light !== exp_light() || o_phase !== exp_phase() || o_ped_pending !== m_pend) begin
        n_fail++;
        $display("FAIL model t=%0t: light %b exp %b, phase %0d exp %0d, pend %b exp %b",
                 $time, o_light, exp_light(), o_phase, exp_phase(), o_ped_pending, m_pend);
      end
    end
  end

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic wait_entry(input logic [5:0] pat, input string nm);
    logic [5:0] prv;
    bit found;
    prv = o_light;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge i_clk); #1;
      if (o_light == pat && prv != pat) found = 1'b1;
      prv = o_light;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting for %b", nm, pat);
    end
  endtask

  // Count further cycles showing pat; leaves the caller 1 time unit past the first other one.
  task automatic measure(input logic [5:0] pat, input int start, output int len);
    bit done;
    len = start;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge i_clk); #1;
      if (o_light == pat) len++;
      else done = 1'b1;
    end
  endtask

  logic [5:0] seq [52];
  int glen, fl;

  initial begin
    begin
      int idx;
      int cnt [6];
      cnt = '{8, 3, 2, 8, 3, 2};
      idx = 0;
      for (int r = 0; r < 2; r++)
        for (int p = 0; p < 6; p++)
          for (int c = 0; c < cnt[p]; c++) begin seq[idx] = lamp[p]; idx++; end
    end

    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("reset_light", o_light, 6'b100001);
    chk("reset_phase", {3'b0, o_phase}, 6'd0);
    chk("reset_pend", {5'b0, o_ped_pending}, 6'd0);

    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;
    for (int k = 0; k < 52; k++) begin
      #1;
      chk($sformatf("idle_seq[%0d]", k), o_light, seq[k]);
      chk($sformatf("model_seq[%0d]", k), exp_light(), seq[k]);
      @(negedge i_clk);
    end

    // Request seen from green cycle 3: green ends once MIN cycles have elapsed.
    @(negedge i_clk); i_ped_req = 1'b1;
    @(negedge i_clk); i_ped_req = 1'b0;
    #1 chk("ped_a_pend", {5'b0, o_ped_pending}, 6'd1);
    measure(6'b100001, 3, glen);
    chk("ped_a_green_len", 6'(glen), 6'd5);
    chk("ped_a_yellow_pend", {5'b0, o_ped_pending}, 6'd1);
    repeat (2) @(negedge i_clk);
    #1 chk("ped_a_yellow3", o_light, 6'b010001);
    @(negedge i_clk);
    #1 chk("ped_a_allred", o_light, 6'b001001);
    chk("ped_a_cleared", {5'b0, o_ped_pending}, 6'd0);

    // Request during ALLRED_A shortens the following EW green.
    i_ped_req = 1'b1;
    @(negedge i_clk); i_ped_req = 1'b0;
    #1 chk("ped_allred_pend", {5'b0, o_ped_pending}, 6'd1);
    wait_entry(6'b001100, "ew_green_entry");
    measure(6'b001100, 1, glen);
    chk("ped_allred_ew_len", 6'(glen), 6'd5);

    // Request sampled at the edge starting green cycle 6: green ends after cycle 6.
    wait_entry(6'b100001, "ns_green_entry");
    repeat (4) @(negedge i_clk);
    i_ped_req = 1'b1;
    @(negedge i_clk); i_ped_req = 1'b0;
    #1 chk("ped_b_cycle6", o_light, 6'b100001);
    @(negedge i_clk);
    #1 chk("ped_b_yellow", o_light, 6'b010001);

    // Request on the ALLRED_A entry edge wins over the clear.
    repeat (2) @(negedge i_clk);
    i_ped_req = 1'b1;
    @(negedge i_clk); i_ped_req = 1'b0;
    #1 chk("set_wins_light", o_light, 6'b001001);
    chk("set_wins_pend", {5'b0, o_ped_pending}, 6'd1);

    // Flash raised in EW green cycle 3, then dropped.
    wait_entry(6'b001100, "ew_green_entry2");
    repeat (2) @(negedge i_clk);
    i_flash = 1'b1;
    @(negedge i_clk); #1 chk("flash_f0", o_light, 6'b010010);
    @(negedge i_clk); #1 chk("flash_f1", o_light, 6'b010010);
    @(negedge i_clk); #1 chk("flash_f2", o_light, 6'b000000);
    @(negedge i_clk); #1 chk("flash_f3", o_light, 6'b000000);
    @(negedge i_clk); #1 chk("flash_f4", o_light, 6'b010010);
    i_flash = 1'b0;
    @(negedge i_clk); #1 chk("flash_exit_r0", o_light, 6'b001001);
    chk("flash_exit_pend", {5'b0, o_ped_pending}, 6'd0);
    @(negedge i_clk); #1 chk("flash_exit_r1", o_light, 6'b001001);
    @(negedge i_clk); #1 chk("flash_exit_ns", o_light, 6'b100001);

    // Flash and request together on the green timeout edge.
    repeat (7) @(negedge i_clk);
    i_flash = 1'b1; i_ped_req = 1'b1;
    @(negedge i_clk); i_ped_req = 1'b0;
    #1 chk("fp_light", o_light, 6'b010010);
    chk("fp_phase", {3'b0, o_phase}, 6'd6);
    chk("fp_pend", {5'b0, o_ped_pending}, 6'd1);
    repeat (3) @(negedge i_clk);
    #1 chk("fp_pend_hold", {5'b0, o_ped_pending}, 6'd1);
    i_flash = 1'b0;
    @(negedge i_clk);
    #1 chk("fp_allred_b", o_light, 6'b001001);
    chk("fp_pend_clr", {5'b0, o_ped_pending}, 6'd0);

    // Asynchronous reset between edges in EW yellow.
    wait_entry(6'b001010, "ew_yellow_entry");
    #1 i_rst_n = 1'b0;
    #1 chk("async_rst_light", o_light, 6'b100001);
    chk("async_rst_pend", {5'b0, o_ped_pending}, 6'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 measure(6'b100001, 1, glen);
    chk("post_rst_green_len", 6'(glen), 6'd8);

    // Randomized pedestrian and flash traffic.
    fl = 0;
    for (int k = 0; k < 2500; k++) begin
      @(negedge i_clk);
      i_ped_req = ($urandom_range(0, 9) == 0);
      if (fl > 0) fl--;
      else if ($urandom_range(0, 149) == 0) fl = $urandom_range(1, 12);
      i_flash = (fl > 0);
    end
    @(negedge i_clk);
    i_ped_req = 1'b0; i_flash = 1'b0;
    repeat (30) @(negedge i_clk);
    chk_en = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
